// File: rtl/vga_noise_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_noise_mixer
//  Purpose  : Output stage in front of the TinyVGA PMOD. Registers the syncs,
//             blanking and 2-bit RGB in two pipeline stages. Adds a masked,
//             frame-faded noise value to each colour channel, saturating at 3.
//             A frame-driven FSM ramps the noise level 0..4 up, holds it at
//             full level, then ramps it back down.
//  Ports    : clk, reset                 - pixel clock, sync active-high reset
//             hsync_in, vsync_in         - syncs from the timing generator
//             display_on                 - visible-area flag
//             r_in, g_in, b_in           - 2-bit colour channels
//             noise, noise_mask          - PRNG byte and per-bit enable
//             fade_en                    - request the fade sequence
//             pmod_out                   - {hs, B0, G0, R0, vs, B1, G1, R1}
//             fade_level, fade_busy      - current level, FSM not idle
//  Revision : 1.0 - initial release
// ============================================================================
module vga_noise_mixer #(
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int STEP_FRAMES      = 4,
    parameter int HOLD_FRAMES      = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [1:0] r_in,
    input  logic [1:0] g_in,
    input  logic [1:0] b_in,
    input  logic [7:0] noise,
    input  logic [7:0] noise_mask,
    input  logic       fade_en,
    output logic [7:0] pmod_out,
    output logic [2:0] fade_level,
    output logic       fade_busy
);

    localparam logic       c_SYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] c_PMOD_RST  = {c_SYNC_IDLE, 3'b000, c_SYNC_IDLE, 3'b000};
    localparam logic [7:0] c_STEP      = 8'(STEP_FRAMES);
    localparam logic [7:0] c_HOLD      = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    // (n * level) >> 2 : level 0..4 scales a 0..3 noise value to 0..3
    function automatic logic [1:0] f_eff(input logic [1:0] n, input logic [2:0] lvl);
        logic [4:0] prod;
        prod = {3'b000, n} * {2'b00, lvl};
        return 2'(prod >> 2);
    endfunction

    function automatic logic [1:0] f_sat(input logic [1:0] c, input logic [1:0] e);
        logic [2:0] sum;
        sum = {1'b0, c} + {1'b0, e};
        return sum[2] ? 2'b11 : sum[1:0];
    endfunction

    state_t     r_state, w_state_nxt;
    logic [2:0] r_level, w_level_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic [7:0] w_count_inc;

    logic       r_hs1, r_vs1, r_de1, r_vs1_d;
    logic [1:0] r_r1, r_g1, r_b1;
    logic [1:0] r_er1, r_eg1, r_eb1;
    logic [7:0] r_pmod;

    logic [1:0] w_nr, w_ng, w_nb;
    logic [1:0] w_r2, w_g2, w_b2;
    logic       w_vs_act, w_vs_act_d, w_tick;
    logic       w_unused;

    // Each channel takes two masked noise bits; bits 4 and 0 carry no colour.
    assign w_nr     = {noise[7] & noise_mask[7], noise[3] & noise_mask[3]};
    assign w_ng     = {noise[6] & noise_mask[6], noise[2] & noise_mask[2]};
    assign w_nb     = {noise[5] & noise_mask[5], noise[1] & noise_mask[1]};
    assign w_unused = ^{noise[4], noise[0], noise_mask[4], noise_mask[0]};

    // Stage 1: register inputs and the noise already scaled by the level in force now
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs1 <= c_SYNC_IDLE;
            r_vs1 <= c_SYNC_IDLE;
            r_de1 <= 1'b0;
            r_r1  <= 2'b00;
            r_g1  <= 2'b00;
            r_b1  <= 2'b00;
            r_er1 <= 2'b00;
            r_eg1 <= 2'b00;
            r_eb1 <= 2'b00;
        end else begin
            r_hs1 <= hsync_in;
            r_vs1 <= vsync_in;
            r_de1 <= display_on;
            r_r1  <= r_in;
            r_g1  <= g_in;
            r_b1  <= b_in;
            r_er1 <= f_eff(w_nr, r_level);
            r_eg1 <= f_eff(w_ng, r_level);
            r_eb1 <= f_eff(w_nb, r_level);
        end
    end

    // Stage 2: saturating add, blanking, pin packing
    assign w_r2 = r_de1 ? f_sat(r_r1, r_er1) : 2'b00;
    assign w_g2 = r_de1 ? f_sat(r_g1, r_eg1) : 2'b00;
    assign w_b2 = r_de1 ? f_sat(r_b1, r_eb1) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pmod  <= c_PMOD_RST;
            r_vs1_d <= c_SYNC_IDLE;
        end else begin
            r_pmod  <= {r_hs1, w_b2[0], w_g2[0], w_r2[0],
                        r_vs1, w_b2[1], w_g2[1], w_r2[1]};
            r_vs1_d <= r_vs1;
        end
    end

    // Frame tick on the asserting edge of the stage-1 vsync
    assign w_vs_act   = (VSYNC_ACTIVE_LOW != 0) ? ~r_vs1   : r_vs1;
    assign w_vs_act_d = (VSYNC_ACTIVE_LOW != 0) ? ~r_vs1_d : r_vs1_d;
    assign w_tick     = w_vs_act & ~w_vs_act_d;

    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
            r_level <= 3'd0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_count_nxt = r_count;
        if (w_tick) begin
            case (r_state)
                S_OFF: begin
                    if (fade_en) begin
                        w_state_nxt = S_RAMP_UP;
                        w_level_nxt = 3'd1;
                        w_count_nxt = 8'd0;
                    end
                end
                S_RAMP_UP: begin
                    if (!fade_en) begin
                        w_level_nxt = r_level - 3'd1;
                        w_count_nxt = 8'd0;
                        w_state_nxt = (r_level == 3'd1) ? S_OFF : S_RAMP_DOWN;
                    end else if (w_count_inc == c_STEP) begin
                        w_level_nxt = r_level + 3'd1;
                        w_count_nxt = 8'd0;
                        w_state_nxt = (r_level == 3'd3) ? S_HOLD : S_RAMP_UP;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                S_HOLD: begin
                    if (!fade_en || (w_count_inc == c_HOLD)) begin
                        w_state_nxt = S_RAMP_DOWN;
                        w_level_nxt = 3'd3;
                        w_count_nxt = 8'd0;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                S_RAMP_DOWN: begin
                    if (w_count_inc == c_STEP) begin
                        w_level_nxt = r_level - 3'd1;
                        w_count_nxt = 8'd0;
                        w_state_nxt = (r_level == 3'd1) ? S_OFF : S_RAMP_DOWN;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_level_nxt = 3'd0;
                    w_count_nxt = 8'd0;
                end
            endcase
        end
    end

    assign pmod_out   = r_pmod;
    assign fade_level = r_level;
    assign fade_busy  = (r_state != S_OFF);

endmodule
`default_nettype wire

// File: tb/tb_vga_noise_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_noise_mixer
//  Purpose  : Self-checking bench for vga_noise_mixer. Two instances with
//             different fade timing share one stimulus stream; a history-based
//             reference model predicts pmod_out, fade_level and fade_busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_noise_mixer;

    localparam int N_DUT  = 2;
    localparam int STEP_A = 1;
    localparam int HOLD_A = 2;
    localparam int STEP_B = 3;
    localparam int HOLD_B = 5;
    localparam int MAXC   = 4096;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_HOLD = 2;
    localparam int M_DOWN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, hsync_in, vsync_in, display_on, fade_en;
    logic [1:0] r_in, g_in, b_in;
    logic [7:0] noise, noise_mask;
    logic [7:0] pmod_a, pmod_b;
    logic [2:0] lvl_a, lvl_b;
    logic       busy_a, busy_b;

    vga_noise_mixer #(.VSYNC_ACTIVE_LOW(1), .STEP_FRAMES(STEP_A), .HOLD_FRAMES(HOLD_A)) dut_a (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .noise(noise), .noise_mask(noise_mask), .fade_en(fade_en),
        .pmod_out(pmod_a), .fade_level(lvl_a), .fade_busy(busy_a));

    vga_noise_mixer #(.VSYNC_ACTIVE_LOW(1), .STEP_FRAMES(STEP_B), .HOLD_FRAMES(HOLD_B)) dut_b (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .noise(noise), .noise_mask(noise_mask), .fade_en(fade_en),
        .pmod_out(pmod_b), .fade_level(lvl_b), .fade_busy(busy_b));

    // Input history, indexed by the clock edge that sampled it
    logic       h_rst [MAXC];
    logic       h_hs  [MAXC];
    logic       h_vs  [MAXC];
    logic       h_de  [MAXC];
    logic       h_en  [MAXC];
    logic [1:0] h_r   [MAXC];
    logic [1:0] h_g   [MAXC];
    logic [1:0] h_b   [MAXC];
    logic [7:0] h_nz  [MAXC];
    logic [7:0] h_mk  [MAXC];
    int         lvl_h [N_DUT][MAXC];   // model level after each edge

    int m_st  [N_DUT];
    int m_cnt [N_DUT];
    int m_lvl [N_DUT];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    // vsync as seen in stage 1 after edge x (reset forces the idle level)
    function automatic logic vs_at(input int x);
        if (x < 0) return 1'b1;
        return h_rst[x] ? 1'b1 : h_vs[x];
    endfunction

    function automatic int chan(input logic de, input logic [1:0] c, input int n, input int lvl);
        int v;
        if (!de) return 0;
        v = int'(c) + (n * lvl) / 4;
        return (v > 3) ? 3 : v;
    endfunction

    function automatic logic [7:0] exp_pmod(input int d, input int c);
        int x, lvl, nr, ng, nb, rr, gg, bb;
        logic [1:0] r2, g2, b2;
        if (c < 1 || h_rst[c] || h_rst[c-1]) return 8'h88;
        x   = c - 1;
        lvl = (x >= 1) ? lvl_h[d][x-1] : 0;
        nr  = 2 * int'(h_nz[x][7] & h_mk[x][7]) + int'(h_nz[x][3] & h_mk[x][3]);
        ng  = 2 * int'(h_nz[x][6] & h_mk[x][6]) + int'(h_nz[x][2] & h_mk[x][2]);
        nb  = 2 * int'(h_nz[x][5] & h_mk[x][5]) + int'(h_nz[x][1] & h_mk[x][1]);
        rr  = chan(h_de[x], h_r[x], nr, lvl);
        gg  = chan(h_de[x], h_g[x], ng, lvl);
        bb  = chan(h_de[x], h_b[x], nb, lvl);
        r2  = rr[1:0];
        g2  = gg[1:0];
        b2  = bb[1:0];
        return {h_hs[x], b2[0], g2[0], r2[0], h_vs[x], b2[1], g2[1], r2[1]};
    endfunction

    // Fade sequence behaviour at edge c for instance d
    task automatic fade_edge(input int d, input int c);
        int  step, hold;
        logic tick;
        step = (d == 0) ? STEP_A : STEP_B;
        hold = (d == 0) ? HOLD_A : HOLD_B;
        tick = (!vs_at(c-1)) && vs_at(c-2);
        if (h_rst[c]) begin
            m_st[d] = M_OFF; m_lvl[d] = 0; m_cnt[d] = 0;
        end else if (tick) begin
            case (m_st[d])
                M_OFF: if (h_en[c]) begin
                    m_st[d] = M_UP; m_lvl[d] = 1; m_cnt[d] = 0;
                end
                M_UP: if (!h_en[c]) begin
                    m_lvl[d] = m_lvl[d] - 1; m_cnt[d] = 0;
                    m_st[d]  = (m_lvl[d] == 0) ? M_OFF : M_DOWN;
                end else begin
                    m_cnt[d]++;
                    if (m_cnt[d] == step) begin
                        m_lvl[d]++; m_cnt[d] = 0;
                        if (m_lvl[d] == 4) m_st[d] = M_HOLD;
                    end
                end
                M_HOLD: begin
                    m_cnt[d]++;
                    if (!h_en[c] || m_cnt[d] == hold) begin
                        m_st[d] = M_DOWN; m_lvl[d] = 3; m_cnt[d] = 0;
                    end
                end
                default: begin
                    m_cnt[d]++;
                    if (m_cnt[d] == step) begin
                        m_lvl[d] = m_lvl[d] - 1; m_cnt[d] = 0;
                        if (m_lvl[d] == 0) m_st[d] = M_OFF;
                    end
                end
            endcase
        end
        lvl_h[d][c] = m_lvl[d];
    endtask

    // One clock: record inputs, advance model at the edge, check on the falling edge
    task automatic cycle();
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow cycle=%0d observed=%0d expected<%0d", cyc, cyc, MAXC);
            $fatal(1, "history overflow");
        end
        h_rst[cyc] = reset;   h_hs[cyc] = hsync_in; h_vs[cyc] = vsync_in;
        h_de[cyc]  = display_on; h_en[cyc] = fade_en;
        h_r[cyc]   = r_in; h_g[cyc] = g_in; h_b[cyc] = b_in;
        h_nz[cyc]  = noise; h_mk[cyc] = noise_mask;
        @(posedge clk);
        for (int d = 0; d < N_DUT; d++) fade_edge(d, cyc);
        @(negedge clk);
        chk("pmod_a", pmod_a, exp_pmod(0, cyc));
        chk("pmod_b", pmod_b, exp_pmod(1, cyc));
        chk("level_a", {5'd0, lvl_a}, 8'(lvl_h[0][cyc]));
        chk("level_b", {5'd0, lvl_b}, 8'(lvl_h[1][cyc]));
        chk("busy_a", {7'd0, busy_a}, {7'd0, (m_st[0] != M_OFF)});
        chk("busy_b", {7'd0, busy_b}, {7'd0, (m_st[1] != M_OFF)});
        cyc++;
    endtask

    task automatic rand_pixels();
        hsync_in   = 1'($urandom_range(0, 1));
        display_on = ($urandom_range(0, 3) != 0);
        r_in       = 2'($urandom_range(0, 3));
        g_in       = 2'($urandom_range(0, 3));
        b_in       = 2'($urandom_range(0, 3));
        noise      = 8'($urandom);
        noise_mask = 8'($urandom);
    endtask

    task automatic idle_pixels();
        hsync_in = 1'b1; display_on = 1'b0;
        r_in = 2'd0; g_in = 2'd0; b_in = 2'd0;
        noise = 8'h00; noise_mask = 8'h00;
    endtask

    // Frame: vsync low two cycles, high two cycles; level settles within it
    task automatic frame();
        for (int i = 0; i < 4; i++) begin
            vsync_in = (i < 2) ? 1'b0 : 1'b1;
            rand_pixels();
            cycle();
        end
    endtask

    int exp_up   [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 1};
    int exp_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    int exp_abrt [4]  = '{3, 2, 1, 0};

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            m_st[d] = M_OFF; m_cnt[d] = 0; m_lvl[d] = 0;
        end
        reset = 1'b1; vsync_in = 1'b1; fade_en = 1'b0;
        idle_pixels();
        @(negedge clk);

        // Reset state
        cycle();
        chk("rst_pmod", pmod_a, 8'h88);
        chk("rst_level", {5'd0, lvl_a}, 8'h00);
        chk("rst_busy", {7'd0, busy_a}, 8'h00);
        reset = 1'b0;
        cycle();

        // Latency and packing
        display_on = 1'b1; r_in = 2'd3; g_in = 2'd0; b_in = 2'd2;
        cycle();
        chk("lat_n1", pmod_a, 8'h88);
        idle_pixels();
        cycle();
        chk("lat_n2", pmod_a, 8'h9D);

        // Full fade sequence, with saturation and blanking probes at level 4
        fade_en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            frame();
            chk("fade_level", {5'd0, lvl_a}, 8'(exp_up[t]));
            chk("fade_busy", {7'd0, busy_a}, 8'(exp_busy[t]));
            if (t == 3) begin
                display_on = 1'b1; hsync_in = 1'b1;
                r_in = 2'd2; g_in = 2'd1; b_in = 2'd0;
                noise = 8'h88; noise_mask = 8'hFF;
                cycle();
                idle_pixels();
                cycle();
                chk("saturate", pmod_a, 8'hB9);
                display_on = 1'b0; hsync_in = 1'b0;
                r_in = 2'd3; g_in = 2'd3; b_in = 2'd3;
                noise = 8'hFF; noise_mask = 8'hFF;
                cycle();
                idle_pixels();
                cycle();
                chk("blank_sync", pmod_a, 8'h08);
            end
        end

        // Up to HOLD, then abort
        for (int t = 0; t < 3; t++) frame();
        chk("hold_level", {5'd0, lvl_a}, 8'h04);
        fade_en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            frame();
            chk("abort_level", {5'd0, lvl_a}, 8'(exp_abrt[t]));
        end
        chk("abort_busy", {7'd0, busy_a}, 8'h00);

        // Reset during ramp-up at level 2
        fade_en = 1'b1;
        frame();
        frame();
        chk("pre_rst_level", {5'd0, lvl_a}, 8'h02);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_level", {5'd0, lvl_a}, 8'h00);
        chk("mid_rst_busy", {7'd0, busy_a}, 8'h00);
        chk("mid_rst_pmod", pmod_a, 8'h88);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) fade_en = ~fade_en;
            if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
            rand_pixels();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
